// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline control: data-access state, register
// index type and the default performance-counter width.
package lc3b_types;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_DONE = 1'b1
    } d_state_t;

    typedef logic [2:0] lc3b_reg;

    localparam int DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != MAX_COUNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: memory-stall freeze, mispredict squash and
// load-use bubble. Define PIPELINE_CTRL_PERF_EN to build the stall/squash counters.
module pipeline_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 icache_resp,
    input  logic                 dcache_resp,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 mem_is_branch,
    input  logic                 mem_br_taken,
    input  logic                 mem_br_predicted,
    input  logic                 ex_is_load,
    input  lc3b_reg              ex_dest,
    input  lc3b_reg              id_sr1,
    input  lc3b_reg              id_sr2,
    input  logic                 id_sr1_valid,
    input  logic                 id_sr2_valid,
    output logic                 icache_read,
    output logic                 dcache_read,
    output logic                 dcache_write,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 squash_if_id,
    output logic                 squash_id_ex,
    output logic                 squash_ex_mem,
    output logic                 pc_redirect,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] squash_count
);

    logic     if_done_reg;
    logic     if_done_next;
    d_state_t d_state_reg;
    d_state_t d_state_next;

    logic d_done;
    logic i_ok;
    logic d_ok;
    logic advance;
    logic mispredict;
    logic load_use;

    assign d_done     = (d_state_reg == D_DONE);
    assign i_ok       = if_done_reg | icache_resp;
    assign d_ok       = ~(mem_read | mem_write) | d_done | dcache_resp;
    assign advance    = i_ok & d_ok;
    assign mispredict = mem_is_branch & (mem_br_taken != mem_br_predicted);
    assign load_use   = ex_is_load &
                        ((id_sr1_valid & (id_sr1 == ex_dest)) |
                         (id_sr2_valid & (id_sr2 == ex_dest)));

    // Flags remember a response that arrived while the other side was still busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_done_reg <= 1'b0;
            d_state_reg <= D_IDLE;
        end else begin
            if_done_reg <= if_done_next;
            d_state_reg <= d_state_next;
        end
    end

    always_comb begin
        if_done_next = if_done_reg;
        if (advance) begin
            if_done_next = 1'b0;
        end else if (icache_resp) begin
            if_done_next = 1'b1;
        end

        d_state_next = d_state_reg;
        case (d_state_reg)
            D_IDLE: if (dcache_resp && !advance) d_state_next = D_DONE;
            D_DONE: if (advance) d_state_next = D_IDLE;
            default: d_state_next = D_IDLE;
        endcase
    end

    always_comb begin
        icache_read   = 1'b0;
        dcache_read   = 1'b0;
        dcache_write  = 1'b0;
        load_pc       = 1'b0;
        load_if_id    = 1'b0;
        load_id_ex    = 1'b0;
        load_ex_mem   = 1'b0;
        load_mem_wb   = 1'b0;
        squash_if_id  = 1'b0;
        squash_id_ex  = 1'b0;
        squash_ex_mem = 1'b0;
        pc_redirect   = 1'b0;

        if (rst_n) begin
            icache_read  = ~if_done_reg;
            dcache_read  = mem_read & ~d_done;
            dcache_write = mem_write & ~d_done;

            // Freeze is the default; a branch flush outranks the load-use bubble.
            if (advance) begin
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                if (mispredict) begin
                    load_pc       = 1'b1;
                    load_if_id    = 1'b1;
                    squash_if_id  = 1'b1;
                    squash_id_ex  = 1'b1;
                    squash_ex_mem = 1'b1;
                    pc_redirect   = 1'b1;
                end else if (load_use) begin
                    squash_id_ex = 1'b1;
                end else begin
                    load_pc    = 1'b1;
                    load_if_id = 1'b1;
                end
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic stall_evt;
    logic squash_evt;

    assign stall_evt  = ~advance | load_use;
    assign squash_evt = advance & mispredict;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_counter (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (stall_evt),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_squash_counter (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (squash_evt),
        .count (squash_count)
    );
`else
    assign stall_count  = '0;
    assign squash_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (4-bit counters so that
// saturation is reachable); counter expectations follow PIPELINE_CTRL_PERF_EN.
module tb_pipeline_ctrl;
    import lc3b_types::*;

    localparam int CW = 4;
`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          icache_resp, dcache_resp, mem_read, mem_write;
    logic          mem_is_branch, mem_br_taken, mem_br_predicted, ex_is_load;
    lc3b_reg       ex_dest, id_sr1, id_sr2;
    logic          id_sr1_valid, id_sr2_valid;
    logic          icache_read, dcache_read, dcache_write;
    logic          load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic          squash_if_id, squash_id_ex, squash_ex_mem, pc_redirect;
    logic [CW-1:0] stall_count, squash_count;
    logic [8:0]    ctl;

    int errors = 0;
    int checks = 0;

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    //  squash_if_id, squash_id_ex, squash_ex_mem, pc_redirect}
    assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  squash_if_id, squash_id_ex, squash_ex_mem, pc_redirect};

    pipeline_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_resp      (icache_resp),
        .dcache_resp      (dcache_resp),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_is_branch    (mem_is_branch),
        .mem_br_taken     (mem_br_taken),
        .mem_br_predicted (mem_br_predicted),
        .ex_is_load       (ex_is_load),
        .ex_dest          (ex_dest),
        .id_sr1           (id_sr1),
        .id_sr2           (id_sr2),
        .id_sr1_valid     (id_sr1_valid),
        .id_sr2_valid     (id_sr2_valid),
        .icache_read      (icache_read),
        .dcache_read      (dcache_read),
        .dcache_write     (dcache_write),
        .load_pc          (load_pc),
        .load_if_id       (load_if_id),
        .load_id_ex       (load_id_ex),
        .load_ex_mem      (load_ex_mem),
        .load_mem_wb      (load_mem_wb),
        .squash_if_id     (squash_if_id),
        .squash_id_ex     (squash_id_ex),
        .squash_ex_mem    (squash_ex_mem),
        .pc_redirect      (pc_redirect),
        .stall_count      (stall_count),
        .squash_count     (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        icache_resp = 1'b1; dcache_resp = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_is_branch = 1'b0; mem_br_taken = 1'b0; mem_br_predicted = 1'b0;
        ex_is_load = 1'b0; ex_dest = 3'd0;
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_sr1_valid = 1'b0; id_sr2_valid = 1'b0;
    endtask

    // Two reset cycles; returns 1 ns after the edge where rst_n is released.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Leave a dcache response pending, then reset over it.
        rst_n = 1'b1;
        idle_inputs();
        icache_resp = 1'b0; mem_read = 1'b1; dcache_resp = 1'b1;
        step();
        rst_n = 1'b0; icache_resp = 1'b1; dcache_resp = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 9'b0) begin
                errors++;
                $display("FAIL reset_ctl cycle=%0d got=%b want=%b", c, ctl, 9'b0);
            end
            checks++;
            if ({icache_read, dcache_read, dcache_write} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mem_req cycle=%0d got=%b want=000", c,
                         {icache_read, dcache_read, dcache_write});
            end
            step();
        end
        checks++;
        if ({stall_count, squash_count} !== '0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, squash_count);
        end
        rst_n = 1'b1; icache_resp = 1'b0; mem_read = 1'b1;
        @(negedge clk);
        checks++;
        if ({icache_read, dcache_read} !== 2'b11) begin
            errors++;
            $display("FAIL reset_discard got=%b want=11", {icache_read, dcache_read});
        end
        $display("test_reset: done");
    endtask

    task automatic test_split_response();
        logic [CW-1:0] exp_stall;
        do_reset();
        mem_read = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            dcache_resp = (k == 2);
            icache_resp = (k == 5);
            @(negedge clk);
            checks++;
            if (dcache_read !== (k <= 2)) begin
                errors++;
                $display("FAIL split_dcache_read cycle=%0d got=%b want=%b", k, dcache_read, (k <= 2));
            end
            checks++;
            if (ctl !== ((k == 5) ? 9'b111110000 : 9'b0)) begin
                errors++;
                $display("FAIL split_ctl cycle=%0d got=%b want=%b", k, ctl,
                         (k == 5) ? 9'b111110000 : 9'b0);
            end
            step();
        end
        exp_stall = PERF ? CW'(4) : CW'(0);
        checks++;
        if (stall_count !== exp_stall) begin
            errors++;
            $display("FAIL split_stall_count got=%0d want=%0d", stall_count, exp_stall);
        end
        // Flags must have cleared on the advance.
        icache_resp = 1'b0; dcache_resp = 1'b0;
        @(negedge clk);
        checks++;
        if ({icache_read, dcache_read} !== 2'b11) begin
            errors++;
            $display("FAIL split_flags_clear got=%b want=11", {icache_read, dcache_read});
        end
        $display("test_split_response: stall_count=%0d", stall_count);
    endtask

    task automatic test_mispredict();
        logic [CW-1:0] exp_sq;
        do_reset();
        mem_is_branch = 1'b1; mem_br_taken = 1'b1; mem_br_predicted = 1'b0;
        mem_read = 1'b1; dcache_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b111111111) begin
            errors++;
            $display("FAIL mispredict_ctl got=%b want=%b", ctl, 9'b111111111);
        end
        step();
        exp_sq = PERF ? CW'(1) : CW'(0);
        checks++;
        if ({squash_count, stall_count} !== {exp_sq, CW'(0)}) begin
            errors++;
            $display("FAIL mispredict_counts got=%0d/%0d want=%0d/0", squash_count, stall_count, exp_sq);
        end
        // Not-taken predicted taken is also a mispredict; matching is not.
        mem_br_taken = 1'b0; mem_br_predicted = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_redirect !== 1'b1) begin
            errors++;
            $display("FAIL mispredict_nt got=%b want=1", pc_redirect);
        end
        step();
        mem_br_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b111110000) begin
            errors++;
            $display("FAIL predicted_ok got=%b want=%b", ctl, 9'b111110000);
        end
        step();
        $display("test_mispredict: squash_count=%0d", squash_count);
    endtask

    task automatic test_load_use();
        logic [CW-1:0] exp_stall;
        do_reset();
        ex_is_load = 1'b1; ex_dest = 3'd3;
        id_sr1 = 3'd5; id_sr1_valid = 1'b1; id_sr2 = 3'd3; id_sr2_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b001110100) begin
            errors++;
            $display("FAIL load_use_sr2 got=%b want=%b", ctl, 9'b001110100);
        end
        step();
        id_sr2_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b111110000) begin
            errors++;
            $display("FAIL load_use_invalid got=%b want=%b", ctl, 9'b111110000);
        end
        step();
        id_sr1 = 3'd3;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b001110100) begin
            errors++;
            $display("FAIL load_use_sr1 got=%b want=%b", ctl, 9'b001110100);
        end
        step();
        ex_is_load = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b111110000) begin
            errors++;
            $display("FAIL load_use_not_load got=%b want=%b", ctl, 9'b111110000);
        end
        step();
        exp_stall = PERF ? CW'(2) : CW'(0);
        checks++;
        if (stall_count !== exp_stall) begin
            errors++;
            $display("FAIL load_use_stall_count got=%0d want=%0d", stall_count, exp_stall);
        end
        $display("test_load_use: stall_count=%0d", stall_count);
    endtask

    task automatic test_priority();
        do_reset();
        mem_is_branch = 1'b1; mem_br_taken = 1'b1; mem_br_predicted = 1'b0;
        ex_is_load = 1'b1; ex_dest = 3'd6; id_sr1 = 3'd6; id_sr1_valid = 1'b1;
        mem_read = 1'b1; dcache_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b111111111) begin
            errors++;
            $display("FAIL priority_mispredict got=%b want=%b", ctl, 9'b111111111);
        end
        step();
        dcache_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 9'b0) begin
            errors++;
            $display("FAIL priority_freeze got=%b want=%b", ctl, 9'b0);
        end
        step();
        $display("test_priority: done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_write = 1'b1; dcache_resp = 1'b1;
        @(negedge clk);
        checks++;
        if ({dcache_write, dcache_read, ctl} !== {2'b10, 9'b111110000}) begin
            errors++;
            $display("FAIL b2b_write_same_cycle got=%b want=%b", {dcache_write, dcache_read, ctl},
                     {2'b10, 9'b111110000});
        end
        step();
        for (int k = 0; k < 3; k++) begin
            dcache_resp = (k == 2);
            @(negedge clk);
            checks++;
            if (load_pc !== (k == 2)) begin
                errors++;
                $display("FAIL b2b_write_wait cycle=%0d got=%b want=%b", k, load_pc, (k == 2));
            end
            step();
        end
        $display("test_back_to_back: done");
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_stall;
        do_reset();
        icache_resp = 1'b0;
        repeat (14) step();
        exp_stall = PERF ? CW'(14) : CW'(0);
        checks++;
        if (stall_count !== exp_stall) begin
            errors++;
            $display("FAIL sat_count14 got=%0d want=%0d", stall_count, exp_stall);
        end
        repeat (6) step();
        exp_stall = PERF ? CW'(15) : CW'(0);
        checks++;
        if (stall_count !== exp_stall) begin
            errors++;
            $display("FAIL sat_count20 got=%0d want=%0d", stall_count, exp_stall);
        end
        $display("test_saturation: stall_count=%0d", stall_count);
    endtask

    initial begin
        test_reset();
        test_split_response();
        test_mispredict();
        test_load_use();
        test_priority();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, 16, width of the performance counters.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: icache_resp, dcache_resp  in  1 each  memory response strobes.
REQ-005 SHALL have ports: mem_read, mem_write  in  1 each  data-access request from the EX/MEM control word.
REQ-006 SHALL have ports: mem_is_branch, mem_br_taken, mem_br_predicted  in  1 each  branch resolved in MEM versus predicted status carried in EX/MEM.
REQ-007 SHALL have ports: ex_is_load  in  1; ex_dest  in  3; id_sr1, id_sr2  in  3 each; id_sr1_valid, id_sr2_valid  in  1 each.
REQ-008 SHALL have ports: icache_read, dcache_read, dcache_write  out  1 each  gated memory requests.
REQ-009 SHALL have ports: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  latch load enables.
REQ-010 SHALL have ports: squash_if_id, squash_id_ex, squash_ex_mem  out  1 each  squash_instruction drives for the latches.
REQ-011 SHALL have ports: pc_redirect  out  1 (PC mux selects resolved target); stall_count, squash_count  out  CNT_WIDTH each.

Function
REQ-012 SHALL hold flags if_done and d_done; d_state SHALL be D_IDLE or D_DONE (d_done=1).
REQ-013 SHALL drive icache_read = rst_n & ~if_done.
REQ-014 SHALL drive dcache_read = rst_n & mem_read & ~d_done, and dcache_write = rst_n & mem_write & ~d_done.
REQ-015 SHALL compute i_ok = if_done | icache_resp, d_ok = ~(mem_read|mem_write) | d_done | dcache_resp, advance = i_ok & d_ok.
REQ-016 SHALL set if_done when icache_resp & ~advance, and d_done (D_IDLE->D_DONE) when dcache_resp & ~advance; both SHALL clear when advance (D_DONE->D_IDLE).
REQ-017 SHALL compute mispredict = mem_is_branch & (mem_br_taken != mem_br_predicted).
REQ-018 SHALL compute load_use = ex_is_load & ((id_sr1_valid & id_sr1==ex_dest) | (id_sr2_valid & id_sr2==ex_dest)).
REQ-019 When ~advance, SHALL drive all load_* and squash_* to 0 (full freeze).
REQ-020 When advance & mispredict, SHALL drive all load_* = 1, squash_if_id = squash_id_ex = squash_ex_mem = 1, and pc_redirect = 1.
REQ-021 When advance & ~mispredict & load_use, SHALL drive load_pc = load_if_id = 0, load_id_ex = load_ex_mem = load_mem_wb = 1, and squash_id_ex = 1 (one bubble).
REQ-022 When advance with neither mispredict nor load_use, SHALL drive all load_* = 1 and all squash_* = 0.
REQ-023 Priority: freeze > mispredict > load_use; pc_redirect SHALL be 1 only under REQ-020.
REQ-024 Outputs are combinational from inputs and flags: zero-cycle latency, and a response arriving in the request cycle advances that cycle.

Reset
REQ-025 While rst_n=0 at a clock edge, SHALL clear if_done, d_done and both counters.
REQ-026 While rst_n=0, SHALL drive all load_*, squash_*, pc_redirect and memory requests to 0; a reset asserted mid-stall discards any pending response.

Configuration
REQ-027 With PIPELINE_CTRL_PERF_EN defined, stall_count SHALL increment on each cycle with ~advance or load_use, and squash_count on each cycle with advance & mispredict, both saturating at all-ones.
REQ-028 Without PIPELINE_CTRL_PERF_EN, counter registers SHALL be absent and stall_count and squash_count SHALL be tied to 0.

Structure
REQ-029 The shared lc3b_types package SHALL hold d_state enum, lc3b_reg (3-bit) typedef and CNT_WIDTH default constant.
REQ-030 SHALL instantiate one sub-module, sat_counter (parameterised width, inc, clear), twice under PIPELINE_CTRL_PERF_EN.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with icache_resp=1 -> all load_*=0, icache_read=0, counters=0.
REQ-032 Split responses: mem_read=1, dcache_resp cycle 2, icache_resp cycle 5 -> dcache_read drops after cycle 2, latches frozen until cycle 5, one advance, stall_count=4.
REQ-033 Mispredict: mem_is_branch=1, taken=1, predicted=0, both responses same cycle -> all three squash=1, pc_redirect=1, squash_count=1.
REQ-034 Load-use: ex_is_load=1, ex_dest=3, id_sr2=3, id_sr2_valid=1 -> load_pc=load_if_id=0, squash_id_ex=1; with id_sr2_valid=0 -> normal advance.
REQ-035 Simultaneous mispredict and load-use with advance -> mispredict behaviour only; with dcache stalled -> all outputs 0.
REQ-036 Saturation (CNT_WIDTH=4): 20 frozen cycles -> stall_count holds 15.
